// File: rtl/sync_fifo_flex_pkg.sv
// Shared types and helpers for the flexible synchronous FIFO and its skid stages.
package sync_fifo_flex_pkg;

  // Occupancy of a two-entry skid stage.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  // True when a pointer sits on the last storage slot and must wrap to zero
  // instead of counting on, so any DEPTH works, not only powers of two.
  function automatic logic is_last_slot(input int unsigned idx, input int unsigned depth);
    return idx == (depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_flex_skid.sv
// Two-entry skid stage: registers the valid/ready path in both directions while
// sustaining one word per cycle. The ready to the producer depends only on local state.
module sync_fifo_flex_skid
  import sync_fifo_flex_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data
);

  skid_state_e       state_q, state_d;
  logic [DWIDTH-1:0] main_q, main_d;
  logic [DWIDTH-1:0] spare_q, spare_d;
  logic              push;
  logic              pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // State and data registers; the spare slot only fills when the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      spare_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      spare_q <= spare_d;
    end
  end

  // Next state: main holds the presented word, spare catches one word of stall.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    spare_d = spare_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          state_d = SKID_ONE;
          main_d  = in_data;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          state_d = SKID_TWO;
          spare_d = in_data;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (pop) begin
          state_d = SKID_ONE;
          main_d  = spare_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // Outputs decode straight from registered state.
  always_comb begin
    in_ready  = (state_q != SKID_TWO);
    out_valid = (state_q != SKID_EMPTY);
    out_data  = main_q;
  end

endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised valid/ready FIFO with arbitrary depth, occupancy count,
// almost-full/empty flags, synchronous flush and optional skid stages per side.
module sync_fifo_flex
  import sync_fifo_flex_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter bit REG_IN    = 1'b1,
  parameter bit REG_OUT   = 1'b1,
  parameter int PW        = $clog2(DEPTH),
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flex: DEPTH must be at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_flex: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("sync_fifo_flex: AE_THRESH must lie in 0..DEPTH-1");
  end

  logic             core_in_valid;
  logic             core_in_ready;
  logic [WIDTH-1:0] core_in_data;
  logic             core_out_valid;
  logic             core_out_ready;
  logic [WIDTH-1:0] core_out_data;

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             wwrap_q, wwrap_d;
  logic             rwrap_q, rwrap_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             ptr_eq;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign ptr_eq         = (wptr_q == rptr_q);
  assign full           = ptr_eq && (wwrap_q != rwrap_q);
  assign empty          = ptr_eq && (wwrap_q == rwrap_q);
  assign core_in_ready  = !full && !flush;
  assign core_out_valid = !empty && !flush;
  assign core_out_data  = mem[rptr_q];
  assign push           = core_in_valid && core_in_ready;
  assign pop            = core_out_valid && core_out_ready;

  // Pointer, wrap and count update; flush wins over any transfer in the same cycle.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    wwrap_d = wwrap_q;
    rwrap_d = rwrap_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      wwrap_d = 1'b0;
      rwrap_d = 1'b0;
      count_d = '0;
    end else begin
      if (push) begin
        if (is_last_slot(32'(wptr_q), DEPTH)) begin
          wptr_d  = '0;
          wwrap_d = !wwrap_q;
        end else begin
          wptr_d = wptr_q + PW'(1);
        end
      end
      if (pop) begin
        if (is_last_slot(32'(rptr_q), DEPTH)) begin
          rptr_d  = '0;
          rwrap_d = !rwrap_q;
        end else begin
          rptr_d = rptr_q + PW'(1);
        end
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Core control state, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      wwrap_q <= 1'b0;
      rwrap_q <= 1'b0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      wwrap_q <= wwrap_d;
      rwrap_q <= rwrap_d;
      count_q <= count_d;
    end
  end

  // Storage array carries no reset; contents are only read once written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= core_in_data;
    end
  end

  assign count        = count_q;
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));

  if (REG_IN) begin : g_reg_in
    sync_fifo_flex_skid #(.DWIDTH(WIDTH)) u_skid_in (
      .clk       (clk),
      .rst       (~rstn),
      .in_valid  (s_valid),
      .in_ready  (s_ready),
      .in_data   (s_data),
      .out_valid (core_in_valid),
      .out_ready (core_in_ready),
      .out_data  (core_in_data)
    );
  end else begin : g_direct_in
    assign core_in_valid = s_valid;
    assign core_in_data  = s_data;
    assign s_ready       = core_in_ready;
  end

  if (REG_OUT) begin : g_reg_out
    sync_fifo_flex_skid #(.DWIDTH(WIDTH)) u_skid_out (
      .clk       (clk),
      .rst       (~rstn),
      .in_valid  (core_out_valid),
      .in_ready  (core_out_ready),
      .in_data   (core_out_data),
      .out_valid (m_valid),
      .out_ready (m_ready),
      .out_data  (m_data)
    );
  end else begin : g_direct_out
    assign m_valid        = core_out_valid;
    assign m_data         = core_out_data;
    assign core_out_ready = m_ready;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench: directed vector table on a 4-deep unregistered FIFO,
// random traffic against a queue model, and a 5-deep fully registered FIFO.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  // Instance A: DEPTH=4, no skid stages, AF=3, AE=1
  logic        a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_af, a_ae;
  logic [31:0] a_s_data, a_m_data;
  logic [2:0]  a_count;

  // Instance B: DEPTH=5, both skid stages
  logic        b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_af, b_ae;
  logic [31:0] b_s_data, b_m_data;
  logic [2:0]  b_count;

  sync_fifo_flex #(.WIDTH(32), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1),
                   .REG_IN(1'b0), .REG_OUT(1'b0)) u_dut_a (
    .clk(clk), .rstn(rstn), .flush(a_flush),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .count(a_count), .almost_full(a_af), .almost_empty(a_ae)
  );

  sync_fifo_flex #(.WIDTH(32), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1),
                   .REG_IN(1'b1), .REG_OUT(1'b1)) u_dut_b (
    .clk(clk), .rstn(rstn), .flush(b_flush),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .count(b_count), .almost_full(b_af), .almost_empty(b_ae)
  );

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        mr;
    logic        fl;
    logic        e_sr;
    logic        e_mv;
    logic [31:0] e_md;
    logic [2:0]  e_cnt;
    logic        e_af;
    logic        e_ae;
  } vec_t;

  vec_t        vecs[16];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    a_s_valid = v.sv;
    a_s_data  = v.sd;
    a_m_ready = v.mr;
    a_flush   = v.fl;
  endtask

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lat;
    int   guard;
    bit   acc_prev;
    logic exp_sr, exp_mv;

    //            sv    data         mr    fl    sr    mv    mdata        cnt   af    ae
    vecs[0]  = '{1'b1, 32'h0000_00A0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 32'h0000_00A1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_00A0, 3'd1, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 32'h0000_00A2, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_00A0, 3'd2, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_00A3, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_00A0, 3'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_00A4, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00A0, 3'd4, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_00A4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_00A0, 3'd4, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_00A4, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_00A1, 3'd3, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_00A1, 3'd4, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_00A2, 3'd3, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_00B0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_00A3, 3'd2, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_00A4, 3'd2, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_00B1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        3'd2, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 32'h0000_00C0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_00C0, 3'd1, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1};

    rstn = 1'b0;
    a_flush = 1'b0; a_s_valid = 1'b0; a_s_data = '0; a_m_ready = 1'b0;
    b_flush = 1'b0; b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_a_s_ready", a_s_ready, 1);
    check_output("rst_a_m_valid", a_m_valid, 0);
    check_output("rst_a_count", a_count, 0);
    check_output("rst_a_af", a_af, 0);
    check_output("rst_a_ae", a_ae, 1);
    check_output("rst_b_s_ready", b_s_ready, 1);
    check_output("rst_b_m_valid", b_m_valid, 0);
    check_output("rst_b_count", b_count, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output($sformatf("vec%0d_s_ready", i), a_s_ready, vecs[i].e_sr);
      check_output($sformatf("vec%0d_m_valid", i), a_m_valid, vecs[i].e_mv);
      check_output($sformatf("vec%0d_count", i), a_count, vecs[i].e_cnt);
      check_output($sformatf("vec%0d_af", i), a_af, vecs[i].e_af);
      check_output($sformatf("vec%0d_ae", i), a_ae, vecs[i].e_ae);
      if (vecs[i].e_mv) check_output($sformatf("vec%0d_m_data", i), a_m_data, vecs[i].e_md);
      @(posedge clk); #1;
    end
    a_s_valid = 1'b0; a_m_ready = 1'b0; a_flush = 1'b0;

    $display("[TB] latency, unregistered instance");
    a_s_valid = 1'b1; a_s_data = 32'h1A7E_0001;
    @(posedge clk); #1;
    a_s_valid = 1'b0;
    lat = 1;
    while (!a_m_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output("lat_a", lat, 1);
    check_output("lat_a_data", a_m_data, 32'h1A7E_0001);
    a_m_ready = 1'b1;
    @(posedge clk); #1;
    a_m_ready = 1'b0;

    $display("[TB] reset mid-operation");
    a_s_valid = 1'b1; a_s_data = 32'h0000_0D01;
    @(posedge clk); #1;
    a_s_data = 32'h0000_0D02;
    @(posedge clk); #1;
    a_s_valid = 1'b0;
    @(negedge clk);
    check_output("midrst_pre_count", a_count, 2);
    #1 rstn = 1'b0;
    #1;
    check_output("midrst_count", a_count, 0);
    check_output("midrst_m_valid", a_m_valid, 0);
    check_output("midrst_s_ready", a_s_ready, 1);
    check_output("midrst_af", a_af, 0);
    check_output("midrst_ae", a_ae, 1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] random traffic against queue model, instance A");
    acc_prev = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (!a_s_valid || acc_prev) begin
        a_s_valid = ($urandom_range(0, 3) != 0);
        a_s_data  = $urandom;
      end
      if (((c / 40) % 2) == 0) a_m_ready = ($urandom_range(0, 3) == 0);
      else                     a_m_ready = ($urandom_range(0, 3) != 0);
      a_flush = ($urandom_range(0, 24) == 0);
      @(negedge clk);
      exp_sr = (qa.size() < 4) && !a_flush;
      exp_mv = (qa.size() > 0) && !a_flush;
      check_output("rand_a_s_ready", a_s_ready, exp_sr);
      check_output("rand_a_m_valid", a_m_valid, exp_mv);
      check_output("rand_a_count", a_count, qa.size());
      check_output("rand_a_af", a_af, qa.size() >= 3);
      check_output("rand_a_ae", a_ae, qa.size() <= 1);
      if (exp_mv) check_output("rand_a_m_data", a_m_data, qa[0]);
      if (a_flush) begin
        qa.delete();
      end else begin
        if (exp_mv && a_m_ready) void'(qa.pop_front());
        if (a_s_valid && exp_sr) qa.push_back(a_s_data);
      end
      acc_prev = a_s_valid && exp_sr;
      @(posedge clk); #1;
    end
    a_s_valid = 1'b0; a_m_ready = 1'b0; a_flush = 1'b0;

    $display("[TB] latency, fully registered instance");
    b_s_valid = 1'b1; b_s_data = 32'h1A7E_0003;
    @(posedge clk); #1;
    b_s_valid = 1'b0;
    lat = 1;
    while (!b_m_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output("lat_b", lat, 3);
    check_output("lat_b_data", b_m_data, 32'h1A7E_0003);
    b_m_ready = 1'b1;
    @(posedge clk); #1;
    b_m_ready = 1'b0;

    $display("[TB] random backpressure scoreboard, instance B");
    acc_prev = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!b_s_valid || acc_prev) begin
        b_s_valid = ($urandom_range(0, 9) < 7);
        b_s_data  = $urandom;
      end
      if (((c / 50) % 2) == 0) b_m_ready = ($urandom_range(0, 9) < 3);
      else                     b_m_ready = ($urandom_range(0, 9) < 9);
      @(negedge clk);
      if (b_m_valid && b_m_ready) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rand_b_spurious actual=%0h required=none", b_m_data);
        end else begin
          check_output("rand_b_m_data", b_m_data, qb.pop_front());
        end
      end
      acc_prev = b_s_valid && b_s_ready;
      if (acc_prev) qb.push_back(b_s_data);
      check_output("rand_b_count_bound", b_count <= 3'd5, 1);
      @(posedge clk); #1;
    end
    b_s_valid = 1'b0;
    b_m_ready = 1'b1;
    guard = 0;
    while (qb.size() > 0 && guard < 40) begin
      @(negedge clk);
      if (b_m_valid) check_output("drain_b_m_data", b_m_data, qb.pop_front());
      @(posedge clk); #1;
      guard++;
    end
    if (qb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_b_timeout actual=%0d required=0 words left", qb.size());
    end
    @(negedge clk);
    check_output("drain_b_m_valid", b_m_valid, 0);
    check_output("drain_b_count", b_count, 0);
    b_m_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
